// File: rtl/clock_ctrl_pkg.sv
// Shared constants and types for the clock's control-input path.
// Channel indices, repeat FSM state and default timing for the conditioner.
package clock_ctrl_pkg;

  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned NUM_BTN = 4;

  // Buttons occupy the low indices so the repeat logic can address them directly
  localparam int unsigned CH_INC_MIN  = 0;
  localparam int unsigned CH_DEC_MIN  = 1;
  localparam int unsigned CH_INC_HOUR = 2;
  localparam int unsigned CH_DEC_HOUR = 3;
  localparam int unsigned CH_SET      = 4;
  localparam int unsigned CH_ALARM    = 5;
  localparam int unsigned CH_MSEL     = 6;
  localparam int unsigned CH_HSEL     = 7;

  localparam int unsigned DEF_DEBOUNCE_CYCLES     = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES = 25_000_000;
  localparam int unsigned DEF_REPEAT_RATE_CYCLES  = 5_000_000;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  // A period of 1 would give $clog2 == 0; keep at least one bit of storage.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One-bit 2-FF synchronizer followed by a counter debounce.
// INVERT normalises polarity after synchronisation so o_level = 1 means active.
module debounce_channel
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_synced;

  assign w_synced = r_sync[1] ^ INVERT;
  assign o_level  = r_level;

  // Sync flops reset to the idle pin level so reset release never looks like an edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync  <= {2{INVERT}};
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      if (w_synced == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_synced;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Turns raw board buttons and switches into debounced levels and step pulses
// with hold-to-repeat and opposite-pair conflict suppression.
module button_conditioner
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter bit          BTN_ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic incr_min_btn,
  input  logic dec_min_btn,
  input  logic incr_hour_btn,
  input  logic dec_hour_btn,
  input  logic time_mode_switch,
  input  logic alarm_mode_switch_raw,
  input  logic min_select_switch,
  input  logic hour_select_switch,
  output logic inc_min,
  output logic dec_min,
  output logic inc_hour,
  output logic dec_hour,
  output logic set_mode,
  output logic alarm_mode_switch,
  output logic min_select,
  output logic hour_select
);

  localparam int unsigned TMR_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                    REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int unsigned   TW         = cnt_width(TMR_MAX);
  localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE_CYCLES - 1);

  if (REPEAT_DELAY_CYCLES < 1) begin : g_bad_delay
    $error("button_conditioner: REPEAT_DELAY_CYCLES must be >= 1");
  end
  if (REPEAT_RATE_CYCLES < 1) begin : g_bad_rate
    $error("button_conditioner: REPEAT_RATE_CYCLES must be >= 1");
  end

  logic [NUM_CH-1:0]  w_raw;
  logic [NUM_CH-1:0]  w_deb;
  logic [NUM_BTN-1:0] w_partner;

  rep_state_t         r_state [NUM_BTN];
  logic [TW-1:0]      r_tmr   [NUM_BTN];
  logic [NUM_BTN-1:0] r_pulse;

  always_comb begin
    w_raw              = '0;
    w_raw[CH_INC_MIN]  = incr_min_btn;
    w_raw[CH_DEC_MIN]  = dec_min_btn;
    w_raw[CH_INC_HOUR] = incr_hour_btn;
    w_raw[CH_DEC_HOUR] = dec_hour_btn;
    w_raw[CH_SET]      = time_mode_switch;
    w_raw[CH_ALARM]    = alarm_mode_switch_raw;
    w_raw[CH_MSEL]     = min_select_switch;
    w_raw[CH_HSEL]     = hour_select_switch;
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          ((ch < NUM_BTN) ? BTN_ACTIVE_LOW : 1'b0)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .i_pin   (w_raw[ch]),
      .o_level (w_deb[ch])
    );
  end

  // Partner of each button within its opposite pair (min pair 0/1, hour pair 2/3)
  assign w_partner = {w_deb[CH_INC_HOUR], w_deb[CH_DEC_HOUR],
                      w_deb[CH_INC_MIN],  w_deb[CH_DEC_MIN]};

  // FSMs keep their schedule during a pair conflict; only the pulse is masked
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pulse <= '0;
      for (int unsigned b = 0; b < NUM_BTN; b++) begin
        r_state[b] <= IDLE;
        r_tmr[b]   <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < NUM_BTN; b++) begin
        r_pulse[b] <= 1'b0;
        case (r_state[b])
          IDLE: begin
            if (w_deb[b]) begin
              r_pulse[b] <= !w_partner[b];
              r_tmr[b]   <= DELAY_LOAD;
              r_state[b] <= DELAY;
            end
          end
          DELAY: begin
            if (!w_deb[b]) begin
              r_state[b] <= IDLE;
            end else if (r_tmr[b] == '0) begin
              r_pulse[b] <= !w_partner[b];
              r_tmr[b]   <= RATE_LOAD;
              r_state[b] <= REPEAT;
            end else begin
              r_tmr[b] <= r_tmr[b] - TW'(1);
            end
          end
          REPEAT: begin
            if (!w_deb[b]) begin
              r_state[b] <= IDLE;
            end else if (r_tmr[b] == '0) begin
              r_pulse[b] <= !w_partner[b];
              r_tmr[b]   <= RATE_LOAD;
            end else begin
              r_tmr[b] <= r_tmr[b] - TW'(1);
            end
          end
          default: r_state[b] <= IDLE;
        endcase
      end
    end
  end

  assign inc_min           = r_pulse[CH_INC_MIN];
  assign dec_min           = r_pulse[CH_DEC_MIN];
  assign inc_hour          = r_pulse[CH_INC_HOUR];
  assign dec_hour          = r_pulse[CH_DEC_HOUR];
  assign set_mode          = w_deb[CH_SET];
  assign alarm_mode_switch = w_deb[CH_ALARM];
  assign min_select        = w_deb[CH_MSEL];
  assign hour_select       = w_deb[CH_HSEL];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a pin-history/hold-time model checked every
// cycle, plus directed scenarios with hand-computed pulse times.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic incr_min_btn = 1'b1, dec_min_btn = 1'b1, incr_hour_btn = 1'b1, dec_hour_btn = 1'b1;
  logic time_mode_switch = 1'b0, alarm_mode_switch_raw = 1'b0;
  logic min_select_switch = 1'b0, hour_select_switch = 1'b0;
  logic inc_min, dec_min, inc_hour, dec_hour;
  logic set_mode, alarm_mode_switch, min_select, hour_select;

  button_conditioner #(
    .DEBOUNCE_CYCLES     (D),
    .REPEAT_DELAY_CYCLES (RD),
    .REPEAT_RATE_CYCLES  (RR),
    .BTN_ACTIVE_LOW      (1'b1)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .incr_min_btn          (incr_min_btn),
    .dec_min_btn           (dec_min_btn),
    .incr_hour_btn         (incr_hour_btn),
    .dec_hour_btn          (dec_hour_btn),
    .time_mode_switch      (time_mode_switch),
    .alarm_mode_switch_raw (alarm_mode_switch_raw),
    .min_select_switch     (min_select_switch),
    .hour_select_switch    (hour_select_switch),
    .inc_min               (inc_min),
    .dec_min               (dec_min),
    .inc_hour              (inc_hour),
    .dec_hour              (dec_hour),
    .set_mode              (set_mode),
    .alarm_mode_switch     (alarm_mode_switch),
    .min_select            (min_select),
    .hour_select           (hour_select)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: hist[j] is the active-high pin sample taken j edges before the
  // previous edge; a level flips once D consecutive synced samples disagree.
  logic [7:0] hist [0:D];
  logic [7:0] deb   = '0;
  logic [3:0] exp_p = '0;
  int         held [4];

  function automatic bit due(input int h);
    return (h == 0) || (h >= RD && ((h - RD) % RR) == 0);
  endfunction

  function automatic logic [7:0] flip_mask();
    logic [7:0] m;
    for (int c = 0; c < 8; c++) begin
      m[c] = 1'b1;
      for (int j = 1; j <= D; j++)
        if (hist[j][c] == deb[c]) m[c] = 1'b0;
    end
    return m;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j <= D; j++) hist[j] <= '0;
      deb   <= '0;
      exp_p <= '0;
      for (int b = 0; b < 4; b++) held[b] <= 0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (deb[b]) begin
          exp_p[b] <= due(held[b]) && !deb[b ^ 1];
          held[b]  <= held[b] + 1;
        end else begin
          exp_p[b] <= 1'b0;
          held[b]  <= 0;
        end
      end
      hist[0] <= {hour_select_switch, min_select_switch, alarm_mode_switch_raw, time_mode_switch,
                  ~dec_hour_btn, ~incr_hour_btn, ~dec_min_btn, ~incr_min_btn};
      for (int j = 1; j <= D; j++) hist[j] <= hist[j-1];
      deb <= deb ^ flip_mask();
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("model_inc_min",     int'(inc_min),           int'(exp_p[0]));
      chk("model_dec_min",     int'(dec_min),           int'(exp_p[1]));
      chk("model_inc_hour",    int'(inc_hour),          int'(exp_p[2]));
      chk("model_dec_hour",    int'(dec_hour),          int'(exp_p[3]));
      chk("model_set_mode",    int'(set_mode),          int'(deb[4]));
      chk("model_alarm_mode",  int'(alarm_mode_switch), int'(deb[5]));
      chk("model_min_select",  int'(min_select),        int'(deb[6]));
      chk("model_hour_select", int'(hour_select),       int'(deb[7]));
    end
  end

  // Edge numbers at which each pulse output was high
  int q [4][$];
  always @(negedge clk) begin
    if (inc_min)  q[0].push_back(cyc);
    if (dec_min)  q[1].push_back(cyc);
    if (inc_hour) q[2].push_back(cyc);
    if (dec_hour) q[3].push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    for (int b = 0; b < 4; b++) q[b].delete();
  endtask

  task automatic all_idle();
    incr_min_btn = 1'b1; dec_min_btn = 1'b1; incr_hour_btn = 1'b1; dec_hour_btn = 1'b1;
    time_mode_switch = 1'b0; alarm_mode_switch_raw = 1'b0;
    min_select_switch = 1'b0; hour_select_switch = 1'b0;
  endtask

  function automatic int outs();
    return int'({hour_select, min_select, alarm_mode_switch, set_mode,
                 dec_hour, inc_hour, dec_min, inc_min});
  endfunction

  int k;
  int exp_rel [8] = '{0, 10, 13, 16, 19, 22, 25, 28};

  initial begin
    // 1: reset with arbitrary pins, then first-press latency
    incr_min_btn = 1'b0; dec_min_btn = 1'b1; incr_hour_btn = 1'b0; dec_hour_btn = 1'b0;
    time_mode_switch = 1'b1; alarm_mode_switch_raw = 1'b1;
    min_select_switch = 1'b0; hour_select_switch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("reset_outputs_zero", outs(), 0);
    end
    rst = 1'b1;
    all_idle();
    step(10);
    clear_q();
    incr_min_btn = 1'b0; k = cyc + 1;
    step(6);
    incr_min_btn = 1'b1;
    step(14);
    chk("t1_pulse_count", q[0].size(), 1);
    if (q[0].size() > 0) chk("t1_first_pulse_edge", q[0][0], k + 6);

    // 2: 3-cycle glitch rejected, 4 stable samples accepted
    step(5);
    clear_q();
    incr_min_btn = 1'b0;
    step(3);
    incr_min_btn = 1'b1;
    step(12);
    chk("t2_glitch_no_pulse", q[0].size(), 0);
    incr_min_btn = 1'b0; k = cyc + 1;
    step(4);
    incr_min_btn = 1'b1;
    step(20);
    chk("t2_stable_one_pulse", q[0].size(), 1);
    if (q[0].size() > 0) chk("t2_pulse_edge", q[0][0], k + 6);

    // 3: hold-to-repeat schedule on dec_hour
    clear_q();
    dec_hour_btn = 1'b0; k = cyc + 1;
    step(30);
    dec_hour_btn = 1'b1;
    step(30);
    chk("t3_pulse_count", q[3].size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < q[3].size()) chk("t3_pulse_edge", q[3][i] - (k + 6), exp_rel[i]);

    // 4: minute pair conflict, hour pair independent
    step(5);
    clear_q();
    incr_min_btn = 1'b0; dec_min_btn = 1'b0; incr_hour_btn = 1'b0; k = cyc + 1;
    step(20);
    dec_min_btn = 1'b1;
    step(10);
    chk("t4_dec_min_silent", q[1].size(), 0);
    chk("t4_inc_min_resume", (q[0].size() > 0) ? q[0][0] : -1, k + 28);
    chk("t4_inc_hour_first", (q[2].size() > 0) ? q[2][0] : -1, k + 6);
    chk("t4_inc_hour_second", (q[2].size() > 1) ? q[2][1] : -1, k + 16);
    incr_min_btn = 1'b1; incr_hour_btn = 1'b1;
    step(20);

    // 5: switch debounce, narrow toggles ignored, no pulses
    clear_q();
    time_mode_switch = 1'b1; k = cyc + 1;
    step(5);
    chk("t5_set_mode_before", int'(set_mode), 0);
    step(1);
    chk("t5_set_mode_rise", int'(set_mode), 1);
    for (int i = 0; i < 3; i++) begin
      time_mode_switch = 1'b0;
      step(2);
      chk("t5_set_mode_hold", int'(set_mode), 1);
      time_mode_switch = 1'b1;
      step(2);
      chk("t5_set_mode_hold", int'(set_mode), 1);
    end
    min_select_switch = 1'b1; hour_select_switch = 1'b1; alarm_mode_switch_raw = 1'b1;
    step(8);
    chk("t5_levels_up", outs(), 8'hF0);
    chk("t5_no_pulses", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
    all_idle();
    step(10);

    // 6: reset during DELAY restarts from full latency
    clear_q();
    incr_min_btn = 1'b0; k = cyc + 1;
    step(8);
    rst = 1'b0;
    step(1);
    chk("t6_reset_outputs_zero", outs(), 0);
    step(1);
    chk("t6_reset_outputs_zero", outs(), 0);
    rst = 1'b1;
    step(19);
    chk("t6_pulse_count", q[0].size(), 3);
    chk("t6_pulse0", (q[0].size() > 0) ? q[0][0] : -1, k + 6);
    chk("t6_pulse1", (q[0].size() > 1) ? q[0][1] : -1, k + 16);
    chk("t6_pulse2", (q[0].size() > 2) ? q[0][2] : -1, k + 26);
    incr_min_btn = 1'b1;
    step(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
